// File: rtl/shifter_pkg.sv
// ============================================================================
// Module : shifter_pkg
// Brief  : Shared mode/direction encodings and FSM states for iterative_shifter
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package shifter_pkg;

   localparam logic [1:0] MODE_FILL   = 2'b00;
   localparam logic [1:0] MODE_SIGN   = 2'b01;
   localparam logic [1:0] MODE_ROTATE = 2'b10;
   localparam logic [1:0] MODE_LOGIC  = 2'b11;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
// Module : shift_step
// Brief  : Combinational single-bit shift of data, spill and overflow state
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_step
   import shifter_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] spill,
   input  logic             ovf,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic             fill,
   output logic [WIDTH-1:0] d_nxt,
   output logic [WIDTH-1:0] spill_nxt,
   output logic             ovf_nxt
);

   logic out_bit;
   logic f;

   always_comb begin
      out_bit = (dir == DIR_LEFT) ? d[WIDTH-1] : d[0];

      case (mode)
         MODE_FILL:   f = fill;
         MODE_SIGN:   f = (dir == DIR_RIGHT) ? d[WIDTH-1] : 1'b0;
         MODE_ROTATE: f = out_bit;
         default:     f = 1'b0;
      endcase

      if (dir == DIR_LEFT) begin
         d_nxt     = {d[WIDTH-2:0], f};
         spill_nxt = {spill[WIDTH-2:0], out_bit};
      end else begin
         d_nxt     = {f, d[WIDTH-1:1]};
         spill_nxt = {out_bit, spill[WIDTH-1:1]};
      end

      // Sticky: a sign change on any step of an arithmetic left shift is overflow
      ovf_nxt = ovf;
      if (mode == MODE_SIGN && dir == DIR_LEFT)
         ovf_nxt = ovf | (d[WIDTH-1] ^ d[WIDTH-2]);
   end

endmodule

`default_nettype wire

// File: rtl/iterative_shifter.sv
// ============================================================================
// Module : iterative_shifter
// Brief  : One-bit-per-clock shifter with valid/ready handshake, fill/sign/rotate
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module iterative_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  logic             in_dir,
   input  logic [1:0]       in_mode,
   input  logic             in_fill,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [WIDTH-1:0] out_spill,
   output logic             out_ovf,
   output logic             busy
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] spill_q, spill_d;
   logic             ovf_q, ovf_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic [1:0]       mode_q, mode_d;
   logic             fill_q, fill_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [WIDTH-1:0] out_spill_q, out_spill_d;
   logic             out_ovf_q, out_ovf_d;
   logic             busy_q, busy_d;

   logic [WIDTH-1:0] step_d;
   logic [WIDTH-1:0] step_spill;
   logic             step_ovf;
   logic             accept;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .d         (d_q),
      .spill     (spill_q),
      .ovf       (ovf_q),
      .dir       (dir_q),
      .mode      (mode_q),
      .fill      (fill_q),
      .d_nxt     (step_d),
      .spill_nxt (step_spill),
      .ovf_nxt   (step_ovf)
   );

   assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      d_d         = d_q;
      spill_d     = spill_q;
      ovf_d       = ovf_q;
      cnt_d       = cnt_q;
      dir_d       = dir_q;
      mode_d      = mode_q;
      fill_d      = fill_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_spill_d = out_spill_q;
      out_ovf_d   = out_ovf_q;
      busy_d      = busy_q;

      case (state_q)
         IDLE, DONE: begin
            if (state_q == DONE && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
            // DONE accepts in the handshake cycle, so there is no bubble
            if (accept) begin
               d_d     = in_data;
               spill_d = '0;
               ovf_d   = 1'b0;
               cnt_d   = in_amt;
               dir_d   = in_dir;
               mode_d  = in_mode;
               fill_d  = in_fill;
               if (in_amt == '0) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  out_data_d  = in_data;
                  out_spill_d = '0;
                  out_ovf_d   = 1'b0;
                  busy_d      = 1'b0;
               end else begin
                  state_d = SHIFT;
                  busy_d  = 1'b1;
               end
            end
         end
         SHIFT: begin
            d_d     = step_d;
            spill_d = step_spill;
            ovf_d   = step_ovf;
            cnt_d   = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               state_d     = DONE;
               busy_d      = 1'b0;
               out_valid_d = 1'b1;
               out_data_d  = step_d;
               out_spill_d = step_spill;
               out_ovf_d   = step_ovf;
            end
         end
         default: begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         d_q         <= '0;
         spill_q     <= '0;
         ovf_q       <= 1'b0;
         cnt_q       <= '0;
         dir_q       <= DIR_LEFT;
         mode_q      <= MODE_FILL;
         fill_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_spill_q <= '0;
         out_ovf_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         d_q         <= d_d;
         spill_q     <= spill_d;
         ovf_q       <= ovf_d;
         cnt_q       <= cnt_d;
         dir_q       <= dir_d;
         mode_q      <= mode_d;
         fill_q      <= fill_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_spill_q <= out_spill_d;
         out_ovf_q   <= out_ovf_d;
         busy_q      <= busy_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_spill = out_spill_q;
   assign out_ovf   = out_ovf_q;
   assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_iterative_shifter.sv
// ============================================================================
// Module : tb_iterative_shifter
// Brief  : Vector-table and scoreboard bench for iterative_shifter at WIDTH=8
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_iterative_shifter;
   import shifter_pkg::*;

   localparam int W  = 8;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [SW-1:0] in_amt;
   logic          in_dir;
   logic [1:0]    in_mode;
   logic          in_fill;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [W-1:0]  out_spill;
   logic          out_ovf;
   logic          busy;

   typedef struct {
      logic [W-1:0]  data;
      logic [SW-1:0] amt;
      logic          dir;
      logic [1:0]    mode;
      logic          fill;
      logic [W-1:0]  e_data;
      logic [W-1:0]  e_spill;
      logic          e_ovf;
   } vec_t;

   typedef struct {
      logic [W-1:0] data;
      logic [W-1:0] spill;
      logic         ovf;
   } res_t;

   res_t sb[$];
   vec_t vecs[14];
   int   n_cmp = 0;
   int   n_err = 0;

   iterative_shifter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_dir    (in_dir),
      .in_mode   (in_mode),
      .in_fill   (in_fill),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_spill (out_spill),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [W-1:0] d, input logic [SW-1:0] a, input logic dir,
                               input logic [1:0] m, input logic f, input logic [W-1:0] ed,
                               input logic [W-1:0] es, input logic eo);
      vec_t v;
      v.data = d; v.amt = a; v.dir = dir; v.mode = m; v.fill = f;
      v.e_data = ed; v.e_spill = es; v.e_ovf = eo;
      return v;
   endfunction

   // Drive one request, push its expected result when the accept edge is due.
   task automatic send(input vec_t v);
      bit   ok;
      res_t r;
      ok       = 1'b0;
      in_data  = v.data;
      in_amt   = v.amt;
      in_dir   = v.dir;
      in_mode  = v.mode;
      in_fill  = v.fill;
      in_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (in_ready) begin
            r.data = v.e_data; r.spill = v.e_spill; r.ovf = v.e_ovf;
            sb.push_back(r);
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = ~v.data;
      in_amt   = ~v.amt;
      in_dir   = ~v.dir;
      in_mode  = ~v.mode;
      in_fill  = ~v.fill;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
      chk("drain_pending", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin : mon
      res_t r;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            r = sb.pop_front();
            chk("res_data",  out_data,  r.data);
            chk("res_spill", out_spill, r.spill);
            chk("res_ovf",   out_ovf,   r.ovf);
         end
      end
   end

   initial begin
      int cyc;
      vecs[0]  = mk(8'hB5, 3'd3, DIR_LEFT,  MODE_FILL,   1'b1, 8'hAF, 8'h05, 1'b0);
      vecs[1]  = mk(8'h96, 3'd2, DIR_RIGHT, MODE_SIGN,   1'b0, 8'hE5, 8'h80, 1'b0);
      vecs[2]  = mk(8'h81, 3'd1, DIR_RIGHT, MODE_ROTATE, 1'b0, 8'hC0, 8'h80, 1'b0);
      vecs[3]  = mk(8'h40, 3'd1, DIR_LEFT,  MODE_SIGN,   1'b0, 8'h80, 8'h00, 1'b1);
      vecs[4]  = mk(8'h20, 3'd1, DIR_LEFT,  MODE_SIGN,   1'b0, 8'h40, 8'h00, 1'b0);
      vecs[5]  = mk(8'hFF, 3'd7, DIR_LEFT,  MODE_LOGIC,  1'b1, 8'h80, 8'h7F, 1'b0);
      vecs[6]  = mk(8'h5A, 3'd0, DIR_RIGHT, MODE_FILL,   1'b1, 8'h5A, 8'h00, 1'b0);
      vecs[7]  = mk(8'h3C, 3'd2, DIR_RIGHT, MODE_FILL,   1'b1, 8'hCF, 8'h00, 1'b0);
      vecs[8]  = mk(8'h81, 3'd4, DIR_LEFT,  MODE_ROTATE, 1'b0, 8'h18, 8'h08, 1'b0);
      vecs[9]  = mk(8'h7F, 3'd7, DIR_RIGHT, MODE_SIGN,   1'b1, 8'h00, 8'hFE, 1'b0);
      vecs[10] = mk(8'hC0, 3'd2, DIR_LEFT,  MODE_SIGN,   1'b0, 8'h00, 8'h03, 1'b1);
      vecs[11] = mk(8'hFF, 3'd3, DIR_RIGHT, MODE_LOGIC,  1'b1, 8'h1F, 8'hE0, 1'b0);
      vecs[12] = mk(8'hA5, 3'd7, DIR_LEFT,  MODE_ROTATE, 1'b0, 8'hD2, 8'h52, 1'b0);
      vecs[13] = mk(8'h60, 3'd2, DIR_LEFT,  MODE_SIGN,   1'b0, 8'h80, 8'h01, 1'b1);

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0;
      in_dir = 1'b0; in_mode = 2'b00; in_fill = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data",  out_data,  0);
      chk("rst_out_spill", out_spill, 0);
      chk("rst_out_ovf",   out_ovf,   0);
      chk("rst_busy",      busy,      0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);

      // Latency: amt=3 result appears three edges after accept
      send(vecs[0]);
      chk("busy_in_shift", busy, 1);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("latency_amt3", cyc, 3);

      // amt=0 is valid right after its accept edge
      send(vecs[6]);
      chk("latency_amt0", out_valid, 1);
      chk("amt0_busy",    busy,      0);
      drain();

      for (int i = 0; i < 14; i++) send(vecs[i]);
      drain();

      // Backpressure: outputs held and no new accept while out_ready is low
      out_ready = 1'b0;
      send(vecs[4]);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid",    out_valid, 1);
         chk("hold_data",     out_data,  8'h40);
         chk("hold_in_ready", in_ready,  0);
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h5A; in_amt = 3'd0; in_dir = DIR_LEFT; in_mode = MODE_FILL; in_fill = 1'b0;
      @(negedge clk);
      chk("no_bubble_ready", in_ready, 1);
      if (in_ready) sb.push_back('{data: 8'h5A, spill: 8'h00, ovf: 1'b0});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("no_bubble_valid", out_valid, 1);
      chk("no_bubble_data",  out_data,  8'h5A);
      drain();

      // Asynchronous reset in the middle of a six-step shift
      send(mk(8'hC3, 3'd6, DIR_LEFT, MODE_FILL, 1'b1, 8'hFF, 8'h30, 1'b0));
      repeat (3) @(posedge clk);
      #1;
      chk("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_busy",      busy,      0);
      chk("abort_out_data",  out_data,  0);
      chk("abort_out_spill", out_spill, 0);
      chk("abort_out_ovf",   out_ovf,   0);
      sb.delete();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      send(vecs[1]);
      send(vecs[3]);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
